// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus arbiter: FSM state encoding and parameter defaults.
package bus_arb_pkg;

    localparam int unsigned N_REQ_DEF    = 4;
    localparam int unsigned W_DEF        = 4;
    localparam int unsigned MAX_HOLD_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner picker: first set req bit at ptr, ptr+1, ... wrapping modulo N_REQ.
// Purely combinational; ptr is expected to be below N_REQ.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] win,
    output logic [PW-1:0]    idx
);

    // Scan from lowest priority to highest so the last hit (offset 0 side) wins.
    always_comb begin
        int k;
        k   = 0;
        win = '0;
        idx = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            k = int'(ptr) + i;
            if (k >= int'(N_REQ)) begin
                k = k - int'(N_REQ);
            end
            if (req[k]) begin
                win    = '0;
                win[k] = 1'b1;
                idx    = PW'(k);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a mandatory one-cycle turnaround between grants.
// Optional grant timeout: define BUS_ARB_TIMEOUT_EN to force release after MAX_HOLD cycles.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned N_REQ    = N_REQ_DEF,
    parameter int unsigned W        = W_DEF,
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] din,
    input  logic [N_REQ-1:0]   done,
    output logic [N_REQ-1:0]   gnt,
    output logic [W-1:0]       z,
    output logic               z_vld,
    output logic               busy
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e       state_q;
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    g_q;
    logic [N_REQ-1:0] win;
    logic [PW-1:0]    win_idx;
    logic             rel;
    logic [PW-1:0]    ptr_next;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr_q),
        .win (win),
        .idx (win_idx)
    );

    assign ptr_next = (g_q == PW'(N_REQ - 1)) ? '0 : g_q + 1'b1;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] hold_q;

    // Only the granted requester's req/done count; timeout forces release even with req held.
    assign rel = !req[g_q] || done[g_q] || (hold_q == HW'(MAX_HOLD));

    // Hold counter: 1 in the first GRANT cycle, counts up while the grant persists.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (state_q == IDLE && |req) begin
            hold_q <= HW'(1);
        end else if (state_q == GRANT && !rel) begin
            hold_q <= hold_q + 1'b1;
        end else begin
            hold_q <= '0;
        end
    end
`else
    logic unused_max_hold;
    assign unused_max_hold = ^MAX_HOLD;

    // Only the granted requester's req/done count toward release.
    assign rel = !req[g_q] || done[g_q];
`endif

    // Arbiter FSM with registered grant, bus value and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            gnt     <= '0;
            z       <= '0;
            z_vld   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q <= GRANT;
                        gnt     <= win;
                        g_q     <= win_idx;
                        z       <= din[int'(win_idx)*W +: W];
                        z_vld   <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        state_q <= TURN;
                        gnt     <= '0;
                        z       <= '0;
                        z_vld   <= 1'b0;
                        busy    <= 1'b0;
                        ptr_q   <= ptr_next;
                    end else begin
                        z <= din[int'(g_q)*W +: W];
                    end
                end
                TURN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (default 4 requesters, 4-bit bus).
module tb_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] din;
    logic [3:0]  done;
    logic [3:0]  gnt;
    logic [3:0]  z;
    logic        z_vld;
    logic        busy;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(
        .N_REQ    (4),
        .W        (4),
        .MAX_HOLD (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .din   (din),
        .done  (done),
        .gnt   (gnt),
        .z     (z),
        .z_vld (z_vld),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [3:0] g_e, input logic [3:0] z_e,
                           input logic v_e);
        chk({tag, ".gnt"}, 32'(gnt), 32'(g_e));
        chk({tag, ".z"}, 32'(z), 32'(z_e));
        chk({tag, ".z_vld"}, 32'(z_vld), 32'(v_e));
        chk({tag, ".busy"}, 32'(busy), 32'(v_e));
    endtask

    initial begin
        logic [3:0] exp_g;
        rst_n = 1'b1;
        req   = '0;
        din   = '0;
        done  = '0;
        #1 rst_n = 1'b0;
        #2;
        chk_bus("reset", 4'b0000, 4'h0, 1'b0);
        tick();
        chk_bus("reset_hold", 4'b0000, 4'h0, 1'b0);
        rst_n = 1'b1;

        // Round-robin order 0,1,2,3,0 with a TURN cycle between grants.
        req = 4'b1111;
        din = 16'hDCBA;
        for (int n = 0; n < 5; n++) begin
            exp_g = 4'b0001 << (n % 4);
            tick();
            chk_bus($sformatf("rr_grant%0d", n), exp_g, 4'hA + 4'(n % 4), 1'b1);
            done = exp_g;
            tick();
            chk_bus($sformatf("rr_turn%0d", n), 4'b0000, 4'h0, 1'b0);
            done = '0;
            if (n == 4) req = '0;
            tick();
            chk_bus($sformatf("rr_idle%0d", n), 4'b0000, 4'h0, 1'b0);
        end

        // Reset mid-grant while requester 2 holds the bus (ptr is now 1).
        req = 4'b0100;
        tick();
        chk("mid_pre.gnt", 32'(gnt), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk_bus("mid_rst", 4'b0000, 4'h0, 1'b0);
        tick();
        chk_bus("mid_rst_hold", 4'b0000, 4'h0, 1'b0);
        req   = 4'b1111;
        rst_n = 1'b1;
        tick();
        chk_bus("post_rst", 4'b0001, 4'hA, 1'b1);
        req = '0;
        tick();
        chk_bus("post_rst_turn", 4'b0000, 4'h0, 1'b0);
        tick();

        // Data path: requester 1 granted (ptr=1), other lanes hold junk.
        din = 16'hFF0F;
        req = 4'b0010;
        for (int v = 0; v < 16; v++) begin
`ifdef BUS_ARB_TIMEOUT_EN
            if (v >= 8) break;
`endif
            din[7:4] = 4'(v);
            tick();
            chk_bus($sformatf("dp%0d", v), 4'b0010, 4'(v), 1'b1);
        end
        req = '0;
        tick();
        chk_bus("dp_turn", 4'b0000, 4'h0, 1'b0);
        tick();

        // Wrap and skip: move ptr to 3 via a grant to requester 2.
        din = 16'h4321;
        req = 4'b0100;
        tick();
        chk("ws_pre.gnt", 32'(gnt), 32'h4);
        req = '0;
        tick();
        tick();
        req = 4'b0101;
        tick();
        chk_bus("ws_wrap", 4'b0001, 4'h1, 1'b1);
        done = 4'b0001;
        tick();
        chk_bus("ws_turn", 4'b0000, 4'h0, 1'b0);
        done = '0;
        tick();
        chk("ws_idle.gnt", 32'(gnt), 32'h0);
        tick();
        chk_bus("ws_skip", 4'b0100, 4'h3, 1'b1);
        req = '0;
        tick();
        tick();

        // Ignored controls: ptr=3, requester 0 granted, foreign done/req ignored.
        req = 4'b0001;
        tick();
        chk("ig_grant.gnt", 32'(gnt), 32'h1);
        done = 4'b0010;
        req  = 4'b1001;
        tick();
        chk_bus("ig_done1", 4'b0001, 4'h1, 1'b1);
        done = '0;
        tick();
        chk("ig_hold.gnt", 32'(gnt), 32'h1);
        done = 4'b0001;
        tick();
        chk("ig_turn.gnt", 32'(gnt), 32'h0);
        done = '0;
        tick();
        chk("ig_idle.gnt", 32'(gnt), 32'h0);
        tick();
        chk_bus("ig_req3", 4'b1000, 4'h4, 1'b1);
        req = '0;
        tick();
        tick();

`ifdef BUS_ARB_TIMEOUT_EN
        // Timeout: ptr=0, req[0] held -> 8 grant cycles, TURN, IDLE, regrant.
        req = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("to_hold%0d.gnt", c), 32'(gnt), 32'h1);
        end
        tick();
        chk_bus("to_turn", 4'b0000, 4'h0, 1'b0);
        tick();
        chk("to_idle.gnt", 32'(gnt), 32'h0);
        tick();
        chk("to_regrant.gnt", 32'(gnt), 32'h1);
        req = '0;
        tick();
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
